// File: rtl/adsr_envelope_poly.sv
// Multi-voice ADSR envelope generator: VOICES independent envelopes sharing controls and beat tick.
// Ports: clk/reset (async active-high), beat tick, per-voice gate, shared attack/decay/sustain/released,
//        packed envelope_out / phase_out levels, per-voice active flag. Outputs registered, 1 clk after beat.
module adsr_envelope_poly #(
    parameter int VOICES      = 4,
    parameter int ENV_W       = 16,
    parameter int RATE_W      = 8,
    parameter int SHIFT       = 8,
    parameter bit RETRIG_ZERO = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      beat,
    input  logic [VOICES-1:0]         gate,
    input  logic [RATE_W-1:0]         attack,
    input  logic [RATE_W-1:0]         decay,
    input  logic [RATE_W-1:0]         sustain,
    input  logic [RATE_W-1:0]         released,
    output logic [VOICES*ENV_W-1:0]   envelope_out,
    output logic [VOICES*3-1:0]       phase_out,
    output logic [VOICES-1:0]         active
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // One guard bit above the envelope so sums and differences can be range-checked before saturating.
    localparam int XW = ENV_W + 1;
    localparam logic [XW-1:0] MAX_X = {1'b0, {ENV_W{1'b1}}};

    logic [XW-1:0] inc_a, inc_d, inc_r, sus_x;

    assign inc_a = {{(XW-RATE_W){1'b0}}, attack}   << SHIFT;
    assign inc_d = {{(XW-RATE_W){1'b0}}, decay}    << SHIFT;
    assign inc_r = {{(XW-RATE_W){1'b0}}, released} << SHIFT;
    assign sus_x = {{(XW-RATE_W){1'b0}}, sustain}  << (ENV_W - RATE_W);

    // Applies one tick of the phase rule for the (already priority-resolved) phase.
    // Returns {next_phase, next_env}.
    function automatic logic [ENV_W+2:0] env_step(
        input logic [2:0]    ph,
        input logic [XW-1:0] e,
        input logic [XW-1:0] ia,
        input logic [XW-1:0] id,
        input logic [XW-1:0] ir,
        input logic [XW-1:0] sl
    );
        logic [2:0]    nph;
        logic [XW-1:0] ne;
        logic [XW-1:0] diff;
        nph  = ph;
        ne   = e;
        diff = e - id;
        case (ph)
            ST_IDLE: ne = '0;
            ST_ATTACK: begin
                ne = e + ia;
                if (ia == '0 || ne >= MAX_X) begin
                    ne  = MAX_X;
                    nph = ST_DECAY;
                end
            end
            ST_DECAY: begin
                // id > e catches the wrapped subtraction before comparing against sustain.
                if (id == '0 || e <= sl || id > e || diff <= sl) begin
                    ne  = sl;
                    nph = ST_SUSTAIN;
                end else begin
                    ne = diff;
                end
            end
            ST_SUSTAIN: ne = sl;
            ST_RELEASE: begin
                if (ir == '0 || ir >= e) begin
                    ne  = '0;
                    nph = ST_IDLE;
                end else begin
                    ne = e - ir;
                end
            end
            default: begin
                ne  = '0;
                nph = ST_IDLE;
            end
        endcase
        return {nph, ne[ENV_W-1:0]};
    endfunction

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic [2:0]       phase_q, phase_d, ph_pre;
        logic [ENV_W-1:0] env_q, env_d;
        logic [XW-1:0]    env_pre;
        logic             trig_q, trig_d, gate_prev_q, trig_now;

        // A gate edge in the same cycle as the tick is consumed by that tick.
        assign trig_now = trig_q | (gate[v] & ~gate_prev_q);
        assign trig_d   = beat ? 1'b0 : trig_now;

        // Trigger beats note-off; both redirect the phase before the step is applied in the same tick.
        always_comb begin
            ph_pre  = phase_q;
            env_pre = {1'b0, env_q};
            if (trig_now) begin
                ph_pre = ST_ATTACK;
                if (RETRIG_ZERO) env_pre = '0;
            end else if (!gate[v] && (phase_q == ST_ATTACK || phase_q == ST_DECAY ||
                                      phase_q == ST_SUSTAIN)) begin
                ph_pre = ST_RELEASE;
            end
        end

        assign {phase_d, env_d} = env_step(ph_pre, env_pre, inc_a, inc_d, inc_r, sus_x);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase_q     <= ST_IDLE;
                env_q       <= '0;
                trig_q      <= 1'b0;
                gate_prev_q <= 1'b0;
            end else begin
                gate_prev_q <= gate[v];
                trig_q      <= trig_d;
                if (beat) begin
                    phase_q <= phase_d;
                    env_q   <= env_d;
                end
            end
        end

        assign envelope_out[v*ENV_W +: ENV_W] = env_q;
        assign phase_out[v*3 +: 3]            = phase_q;
        assign active[v]                      = (phase_q != ST_IDLE);
    end

endmodule

// File: tb/tb_adsr_envelope_poly.sv
module tb_adsr_envelope_poly;
    localparam int V    = 4;
    localparam int EW   = 16;
    localparam int MAXV = 65535;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          beat = 1'b0;
    logic [V-1:0]  gate = '0;
    logic [7:0]    attack = 8'd0, decay = 8'd0, sustain = 8'd0, released = 8'd0;
    logic [V*EW-1:0] env1, env0;
    logic [V*3-1:0]  ph1, ph0;
    logic [V-1:0]    act1, act0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Build 1: retrigger restarts from zero. Build 0: legato retrigger.
    adsr_envelope_poly #(.VOICES(V), .ENV_W(EW), .RATE_W(8), .SHIFT(8), .RETRIG_ZERO(1'b1)) dut_z (
        .clk(clk), .reset(reset), .beat(beat), .gate(gate),
        .attack(attack), .decay(decay), .sustain(sustain), .released(released),
        .envelope_out(env1), .phase_out(ph1), .active(act1));

    adsr_envelope_poly #(.VOICES(V), .ENV_W(EW), .RATE_W(8), .SHIFT(8), .RETRIG_ZERO(1'b0)) dut_l (
        .clk(clk), .reset(reset), .beat(beat), .gate(gate),
        .attack(attack), .decay(decay), .sustain(sustain), .released(released),
        .envelope_out(env0), .phase_out(ph0), .active(act0));

    function automatic int envo(int b, int v);
        return b ? int'(env1[v*EW +: EW]) : int'(env0[v*EW +: EW]);
    endfunction
    function automatic int pho(int b, int v);
        return b ? int'(ph1[v*3 +: 3]) : int'(ph0[v*3 +: 3]);
    endfunction
    function automatic int acto(int b, int v);
        return b ? int'(act1[v]) : int'(act0[v]);
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [V*EW-1:0] e1;
        logic [V*EW-1:0] e0;
        logic [V*3-1:0]  p1;
        logic [V*3-1:0]  p0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mod_e;
    exp_t mon_e;
    int   m_env [2][V];
    int   m_ph  [2][V];   // 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    bit   m_trig [V];
    bit   m_gprev [V];
    bit   m_tr;

    task automatic model_step(input int b, input int v, input bit trig, input bit g);
        int e, p, ia, id, ir, sl;
        e  = m_env[b][v];
        p  = m_ph[b][v];
        ia = int'(attack) * 256;
        id = int'(decay) * 256;
        ir = int'(released) * 256;
        sl = int'(sustain) * 256;
        if (trig) begin
            p = 1;
            if (b == 1) e = 0;
        end else if (!g && p >= 1 && p <= 3) begin
            p = 4;
        end
        case (p)
            0: e = 0;
            1: begin
                if (ia == 0) e = MAXV;
                else e = (e + ia > MAXV) ? MAXV : e + ia;
                if (e == MAXV) p = 2;
            end
            2: begin
                if (id == 0 || e <= sl) e = sl;
                else e = (e - id < sl) ? sl : e - id;
                if (e == sl) p = 3;
            end
            3: e = sl;
            default: begin
                if (ir == 0) e = 0;
                else e = (e - ir < 0) ? 0 : e - ir;
                if (e == 0) p = 0;
            end
        endcase
        m_env[b][v] = e;
        m_ph[b][v]  = p;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < V; v++) begin
                for (int b = 0; b < 2; b++) begin
                    m_env[b][v] = 0;
                    m_ph[b][v]  = 0;
                end
                m_trig[v]  = 1'b0;
                m_gprev[v] = 1'b0;
            end
            exp_q.delete();
        end else begin
            for (int v = 0; v < V; v++) begin
                m_tr = m_trig[v] | (gate[v] & !m_gprev[v]);
                if (beat) begin
                    model_step(0, v, m_tr, gate[v]);
                    model_step(1, v, m_tr, gate[v]);
                    m_trig[v] = 1'b0;
                end else begin
                    m_trig[v] = m_tr;
                end
                m_gprev[v] = gate[v];
            end
            if (beat) begin
                for (int v = 0; v < V; v++) begin
                    mod_e.e1[v*EW +: EW] = EW'(m_env[1][v]);
                    mod_e.e0[v*EW +: EW] = EW'(m_env[0][v]);
                    mod_e.p1[v*3 +: 3]   = 3'(m_ph[1][v]);
                    mod_e.p0[v*3 +: 3]   = 3'(m_ph[0][v]);
                end
                exp_q.push_back(mod_e);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int v = 0; v < V; v++) begin
                chk($sformatf("rz1 v%0d env", v), envo(1, v), int'(mon_e.e1[v*EW +: EW]));
                chk($sformatf("rz0 v%0d env", v), envo(0, v), int'(mon_e.e0[v*EW +: EW]));
                chk($sformatf("rz1 v%0d phase", v), pho(1, v), int'(mon_e.p1[v*3 +: 3]));
                chk($sformatf("rz0 v%0d phase", v), pho(0, v), int'(mon_e.p0[v*3 +: 3]));
                chk($sformatf("rz1 v%0d active", v), acto(1, v), int'(mon_e.p1[v*3 +: 3] != 3'd0));
                chk($sformatf("rz0 v%0d active", v), acto(0, v), int'(mon_e.p0[v*3 +: 3] != 3'd0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int gap);
        @(negedge clk) beat = 1'b1;
        @(negedge clk) beat = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, " env"},    int'(|{env1, env0}), 0);
        chk({nm, " phase"},  int'(|{ph1, ph0}), 0);
        chk({nm, " active"}, int'(|{act1, act0}), 0);
    endtask

    function automatic logic [7:0] rnd_rate();
        case ($urandom_range(3))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    initial begin
        #2 reset = 1'b1;
        #2 chk_all_zero("reset state");
        @(negedge clk);
        @(negedge clk) reset = 1'b0;

        // Attack ramp on voice 0.
        attack = 8'd10; decay = 8'd10; sustain = 8'd128; released = 8'd20;
        gate[0] = 1'b1;
        for (int i = 0; i < 25; i++) tick(0);
        chk("attack tick25 env", envo(1, 0), 64000);
        tick(8);
        chk("attack clamp env", envo(1, 0), MAXV);
        chk("attack clamp phase", pho(1, 0), 2);

        // Decay down to sustain.
        for (int i = 0; i < 12; i++) tick(2);
        chk("decay tick12 env", envo(1, 0), 34815);
        tick(2);
        chk("decay floor env", envo(1, 0), 32768);
        chk("decay floor phase", pho(1, 0), 3);
        sustain = 8'd200;
        tick(1);
        chk("sustain track env", envo(1, 0), 51200);
        chk("sustain track phase", pho(1, 0), 3);
        sustain = 8'd128;
        tick(1);

        // Release to idle.
        gate[0] = 1'b0;
        tick(1);
        chk("release first env", envo(1, 0), 27648);
        for (int i = 0; i < 6; i++) tick(1);
        chk("release end env", envo(1, 0), 0);
        chk("release end phase", pho(1, 0), 0);
        chk("release end active", acto(1, 0), 0);

        // Zero release rate: instant drop.
        released = 8'd0;
        gate[0] = 1'b1;
        tick(1);
        gate[0] = 1'b0;
        tick(1);
        chk("instant release env", envo(1, 0), 0);
        chk("instant release phase", pho(1, 0), 0);

        // Retrigger during release on voice 1, both builds.
        released = 8'd20;
        gate[1] = 1'b1;
        for (int i = 0; i < 8; i++) tick(0);
        gate[1] = 1'b0;
        tick(1);
        chk("pre-retrig env", envo(0, 1), 15360);
        gate[1] = 1'b1;
        tick(1);
        chk("legato retrig env", envo(0, 1), 17920);
        chk("legato retrig phase", pho(0, 1), 1);
        chk("zero retrig env", envo(1, 1), 2560);

        // Short gate pulse on voice 2 between ticks.
        released = 8'd1;
        gate[2] = 1'b1;
        @(negedge clk);
        @(negedge clk) gate[2] = 1'b0;
        repeat (2) @(negedge clk);
        tick(1);
        chk("pulse attack phase", pho(1, 2), 1);
        chk("pulse attack env", envo(1, 2), 2560);
        tick(1);
        chk("pulse release phase", pho(1, 2), 4);
        chk("pulse release env", envo(1, 2), 2304);
        released = 8'd20;
        tick(1);
        chk("pulse back to zero", envo(1, 2), 0);

        // Zero attack rate on voice 3: full scale in one tick.
        attack = 8'd0;
        gate[3] = 1'b1;
        tick(1);
        chk("instant attack env", envo(1, 3), MAXV);
        chk("instant attack phase", pho(1, 3), 2);

        // Reset mid-attack on voice 3.
        attack = 8'd10;
        gate[3] = 1'b0;
        tick(1);
        gate[3] = 1'b1;
        tick(0);
        chk("pre-reset phase", pho(1, 3), 1);
        #3 reset = 1'b1;
        #1 chk_all_zero("async reset");
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("post reset no tick");

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            beat = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) gate = gate ^ 4'($urandom_range(15));
            if ($urandom_range(40) == 0) attack   = rnd_rate();
            if ($urandom_range(40) == 0) decay    = rnd_rate();
            if ($urandom_range(40) == 0) sustain  = rnd_rate();
            if ($urandom_range(40) == 0) released = rnd_rate();
        end
        @(negedge clk) beat = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adsr_envelope_poly.md
Name: adsr_envelope_poly

Overview:
- Parametrised multi-voice successor to the single-voice ADSR envelope generator.
- Runs VOICES independent ADSR state machines in parallel. All voices share the attack/decay/sustain/release controls and the beat tick from beat_generator.
- Adds per-voice gates, instant-phase handling for zero rates, selectable retrigger mode and per-voice phase/active status.
- Sits between the beat generator and the per-voice amplitude multipliers in the synth path.

Parameters:
- VOICES, 4, number of independent envelope channels (1..16)
- ENV_W, 16, envelope output width; full scale MAX = 2^ENV_W-1
- RATE_W, 8, width of the attack/decay/sustain/released controls
- SHIFT, 8, left shift applied to rate values to form per-tick step; requires SHIFT+RATE_W <= ENV_W
- RETRIG_ZERO, 1, 1: a new trigger restarts attack from 0; 0: attack continues from the current level (legato)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- beat  in  1  one-clk envelope update tick
- gate  in  VOICES  per-voice note-on level; bit i drives voice i
- attack  in  RATE_W  attack rate
- decay  in  RATE_W  decay rate
- sustain  in  RATE_W  sustain level
- released  in  RATE_W  release rate
- envelope_out  out  VOICES*ENV_W  packed levels; voice i at [i*ENV_W +: ENV_W]
- phase_out  out  VOICES*3  packed phase codes
- active  out  VOICES  1 when the voice phase != IDLE

Behaviour:
- Reset is asynchronous and active-high: clk is the single clock; reset clears all state immediately. While reset is high, all voices sit in IDLE, envelope_out=0, phase_out=0, active=0, trigger flags=0 and previous-gate registers=0. This holds when reset is asserted mid-note too; no release tail follows.
- Phase codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5-7 never occur; an illegal state recovers to IDLE with env=0.
- Step values: inc_a = attack<<SHIFT, inc_d = decay<<SHIFT, inc_r = released<<SHIFT. Sustain level sus_lvl = sustain<<(ENV_W-RATE_W).
- Arithmetic is done at ENV_W+1 bits to detect overflow and underflow; results saturate and never wrap.
- Trigger capture: on every clk, a rising edge of gate[i] sets trig_pend[i]. The flag is cleared only when consumed on a beat. Gate pulses shorter than a beat interval still trigger.
- Updates happen only on a clk edge with beat=1. Outputs are registered, so they reflect the tick on the cycle after beat is high. All controls are sampled live at each tick, so mid-phase changes take effect on the next tick.
- Per-voice transition priority, evaluated on each tick:
  1. trig_pend set → ATTACK. env is first set to 0 if RETRIG_ZERO=1, otherwise kept. The ATTACK step below is then applied in the same tick. trig_pend is cleared.
  2. gate low and phase is ATTACK, DECAY or SUSTAIN → RELEASE. The release step is applied in the same tick.
  3. Otherwise the phase rules below apply.
- IDLE: env stays 0.
- ATTACK:
  - inc_a==0 → env=MAX and go to DECAY.
  - Otherwise env=min(env+inc_a, MAX); when the result is MAX, go to DECAY.
- DECAY:
  - If env<=sus_lvl, or inc_d==0 → env=sus_lvl and go to SUSTAIN.
  - Otherwise env=max(env-inc_d, sus_lvl); when the result equals sus_lvl, go to SUSTAIN.
- SUSTAIN: env tracks sus_lvl on every tick, whether sus_lvl rises or falls.
- RELEASE:
  - inc_r==0 → env=0 and go to IDLE.
  - Otherwise env=max(env-inc_r, 0); when the result is 0, go to IDLE.
  - Gate going high again during RELEASE retriggers through rule 1.
- Gate edge and tick in the same cycle: the edge counts as consumed in that tick.
- Voices are fully independent. No shared state other than the controls.

Test Plan:
- Defaults; attack=10 (inc 2560); gate[0] rises; tick every 10 clk → voice 0 envelope reads 2560, 5120, … 64000; tick 26 clamps to 65535 with phase=2. Other voices stay 0 and IDLE.
- Continue with decay=10, sustain=128 (sus_lvl 32768) → 65535, 62975, … 34815; tick 13 gives 32768 with phase=3. Then change sustain to 200 → next tick env=51200 and the voice stays in SUSTAIN.
- Gate[0] falls during SUSTAIN at 32768, released=20 (inc 5120) → 27648, 22528, …; tick 7 gives 0 with phase=0 and active[0]=0. Then released=0 on a fresh note-off → env=0 in one tick.
- RETRIG_ZERO=0 build: gate[1] re-rises while RELEASE is at 20000 with attack=10 → next tick 22560, phase=1. RETRIG_ZERO=1 build, same stimulus → next tick 2560.
- Gate[2] pulses high for 2 clk between ticks → next tick phase=1 then RELEASE on the following tick, and the level returns to 0. attack=0 → env jumps to 65535 in one tick.
- Assert reset mid-attack on voice 3 for 1 clk → all outputs 0 asynchronously. After release of reset, with no tick yet, the outputs still read 0.
